systolic_array_sequencer: RTL and testbench

Tile-level sequencer for the NxN systolic array. It accepts row loads of weights, inputs and partial sums from the memory-side bus and tracks which rows are present. Once a tile is complete it runs the skewed FIFO-shift and MAC schedule, then hands the N output rows to the writeback side with a valid/ready handshake. It sits between the memory bus and the array/FIFO datapath and produces the control-unit outputs those blocks consume.

---
 rtl/systolic_array_sequencer_pkg.sv | 17 +
 rtl/systolic_array_sequencer_skew_gen.sv | 28 ++
 rtl/systolic_array_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_systolic_array_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_array_sequencer_pkg.sv
// Shared types and defaults for the systolic array tile sequencer.
package systolic_pkg;

  // Tile life cycle: gather rows, run the skewed schedule, hand rows out.
  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } sa_seq_state_t;

  localparam int DEF_N       = 4;
  localparam int DEF_MAC_LAT = 3;
  localparam int DEF_RW      = $clog2(DEF_N);

  typedef logic [DEF_RW-1:0] row_idx_t;

endpackage

// File: rtl/systolic_array_sequencer_skew_gen.sv
// Skewed shift windows for the input FIFOs (rows) and partial-sum FIFOs
// (columns). Shifts only happen on the first cycle of each systolic step.
module sa_skew_gen #(
  parameter int N  = 4,
  parameter int SW = 4,
  parameter int CW = 1
) (
  input  logic [SW-1:0] i_s,
  input  logic [CW-1:0] i_c,
  output logic [N-1:0]  o_fifo_shift,
  output logic [N-1:0]  o_ps_fifo_shift
);

  // Row i feeds during steps i..i+N-1; column j drains during j+N-1..j+2N-2.
  always_comb begin
    o_fifo_shift    = '0;
    o_ps_fifo_shift = '0;
    if (i_c == '0) begin
      for (int k = 0; k < N; k++) begin
        if ((int'(i_s) >= k) && (int'(i_s) <= k + N - 1))
          o_fifo_shift[k] = 1'b1;
        if ((int'(i_s) >= k + N - 1) && (int'(i_s) <= k + 2 * N - 2))
          o_ps_fifo_shift[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_array_sequencer.sv
// Tile sequencer: collects weight/input/partial rows, runs the skewed MAC
// schedule, then streams the N output rows to writeback.
//
// Handshake: an output row moves when out_valid & out_ready are both high at
// a rising clock edge; out_valid and row_out stay stable until that happens.
// On the load side bus_ready is the ready term, the *_en inputs are the valid.
module systolic_array_sequencer
  import systolic_pkg::*;
#(
  parameter  int N       = DEF_N,
  parameter  int MAC_LAT = DEF_MAC_LAT,
  localparam int RW      = $clog2(N)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          weight_en,
  input  logic          input_en,
  input  logic          partial_en,
  input  logic [RW-1:0] row_en,
  input  logic          fifo_has_space,
  input  logic          out_ready,
  output logic          bus_ready,
  output logic          weight_load,
  output logic [RW-1:0] weight_row,
  output logic          input_load,
  output logic [RW-1:0] input_row,
  output logic          partials_load,
  output logic [RW-1:0] partials_row,
  output logic [N-1:0]  fifo_shift,
  output logic [N-1:0]  ps_fifo_shift,
  output logic          MAC_start,
  output logic          MAC_count,
  output logic [RW-1:0] row_out,
  output logic          out_valid,
  output logic          busy,
  output logic          tile_done,
  output logic [1:0]    dbg_state
);

  localparam int SW = $clog2(3 * N);
  localparam int CW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [SW-1:0] S_LAST   = SW'(3 * N - 3);
  localparam logic [CW-1:0] C_LAST   = CW'(MAC_LAT - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);

  sa_seq_state_t r_state, w_state_nxt;
  logic [N-1:0]  r_w_mask, r_i_mask, r_p_mask;
  logic [N-1:0]  w_w_mask_nxt, w_i_mask_nxt, w_p_mask_nxt;
  logic [SW-1:0] r_s, w_s_nxt;
  logic [CW-1:0] r_c, w_c_nxt;
  logic [RW-1:0] r_row, w_row_nxt;
  logic          w_done_nxt;
  logic          w_acc_w, w_acc_i, w_acc_p;
  logic [N-1:0]  w_row_bit;
  logic [N-1:0]  w_fifo_shift, w_ps_fifo_shift;

  assign bus_ready = (r_state == LOAD) & fifo_has_space;
  assign w_acc_w   = bus_ready & weight_en;
  assign w_acc_i   = bus_ready & ~weight_en & input_en;
  assign w_acc_p   = bus_ready & ~weight_en & ~input_en & partial_en;
  assign w_row_bit = N'(1) << row_en;
  assign dbg_state = r_state;

  // Skew windows evaluated on the next-cycle counters so the registered
  // shift outputs line up with the step they belong to.
  sa_skew_gen #(.N(N), .SW(SW), .CW(CW)) u_skew (
    .i_s             (w_s_nxt),
    .i_c             (w_c_nxt),
    .o_fifo_shift    (w_fifo_shift),
    .o_ps_fifo_shift (w_ps_fifo_shift)
  );

  // Next-state, counter and row-mask logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_w_mask_nxt = r_w_mask;
    w_i_mask_nxt = r_i_mask;
    w_p_mask_nxt = r_p_mask;
    w_s_nxt      = r_s;
    w_c_nxt      = r_c;
    w_row_nxt    = r_row;
    w_done_nxt   = 1'b0;
    case (r_state)
      LOAD: begin
        if (w_acc_w) w_w_mask_nxt = r_w_mask | w_row_bit;
        if (w_acc_i) w_i_mask_nxt = r_i_mask | w_row_bit;
        if (w_acc_p) w_p_mask_nxt = r_p_mask | w_row_bit;
        if ((&w_w_mask_nxt) && (&w_i_mask_nxt) && (&w_p_mask_nxt)) begin
          w_state_nxt = COMPUTE;
          w_s_nxt     = '0;
          w_c_nxt     = '0;
        end
      end
      COMPUTE: begin
        if (r_c == C_LAST) begin
          w_c_nxt = '0;
          if (r_s == S_LAST) begin
            w_state_nxt = DRAIN;
            w_row_nxt   = '0;
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end else begin
          w_c_nxt = r_c + CW'(1);
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          if (r_row == ROW_LAST) begin
            w_state_nxt  = LOAD;
            w_row_nxt    = '0;
            w_w_mask_nxt = '0;
            w_i_mask_nxt = '0;
            w_p_mask_nxt = '0;
            w_done_nxt   = 1'b1;
          end else begin
            w_row_nxt = r_row + RW'(1);
          end
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  // State, counters and row masks.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state  <= LOAD;
      r_w_mask <= '0;
      r_i_mask <= '0;
      r_p_mask <= '0;
      r_s      <= '0;
      r_c      <= '0;
      r_row    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_w_mask <= w_w_mask_nxt;
      r_i_mask <= w_i_mask_nxt;
      r_p_mask <= w_p_mask_nxt;
      r_s      <= w_s_nxt;
      r_c      <= w_c_nxt;
      r_row    <= w_row_nxt;
    end
  end

  // Registered control outputs derived from the next-cycle state.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      weight_load   <= 1'b0;
      weight_row    <= '0;
      input_load    <= 1'b0;
      input_row     <= '0;
      partials_load <= 1'b0;
      partials_row  <= '0;
      fifo_shift    <= '0;
      ps_fifo_shift <= '0;
      MAC_start     <= 1'b0;
      MAC_count     <= 1'b0;
      row_out       <= '0;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
      tile_done     <= 1'b0;
    end else begin
      weight_load   <= w_acc_w;
      weight_row    <= w_acc_w ? row_en : '0;
      input_load    <= w_acc_i;
      input_row     <= w_acc_i ? row_en : '0;
      partials_load <= w_acc_p;
      partials_row  <= w_acc_p ? row_en : '0;
      fifo_shift    <= (w_state_nxt == COMPUTE) ? w_fifo_shift : '0;
      ps_fifo_shift <= (w_state_nxt == COMPUTE) ? w_ps_fifo_shift : '0;
      MAC_start     <= (r_state == LOAD) && (w_state_nxt == COMPUTE);
      MAC_count     <= (w_state_nxt == COMPUTE);
      row_out       <= (w_state_nxt == DRAIN) ? w_row_nxt : '0;
      out_valid     <= (w_state_nxt == DRAIN);
      busy          <= (w_state_nxt != LOAD);
      tile_done     <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Bench for systolic_array_sequencer: two instances (MAC_LAT=1 and 3) share
// the bus stimulus; per-instance monitors check against expected queues.
module tb_systolic_array_sequencer;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       weight_en, input_en, partial_en;
  logic [1:0] row_en;
  logic       fifo_has_space, out_ready;

  logic       a_bus_ready, a_weight_load, a_input_load, a_partials_load;
  logic [1:0] a_weight_row, a_input_row, a_partials_row, a_row_out, a_dbg_state;
  logic [3:0] a_fifo_shift, a_ps_fifo_shift;
  logic       a_MAC_start, a_MAC_count, a_out_valid, a_busy, a_tile_done;

  logic       b_bus_ready, b_weight_load, b_input_load, b_partials_load;
  logic [1:0] b_weight_row, b_input_row, b_partials_row, b_row_out, b_dbg_state;
  logic [3:0] b_fifo_shift, b_ps_fifo_shift;
  logic       b_MAC_start, b_MAC_count, b_out_valid, b_busy, b_tile_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic mon_en = 1'b0;

  logic [4:0] load_exp_q[$];
  logic [8:0] cmpa_exp_q[$];
  logic [8:0] cmpb_exp_q[$];
  logic [1:0] rowa_exp_q[$];
  logic [1:0] rowb_exp_q[$];
  logic a_done_exp = 1'b0;
  logic b_done_exp = 1'b0;

  logic [3:0] fs_tab [10];
  logic [3:0] ps_tab [10];
  logic [4:0] tile_tab [12];

  wire [23:0] a_regs = {a_weight_load, a_weight_row, a_input_load, a_input_row,
                        a_partials_load, a_partials_row, a_fifo_shift, a_ps_fifo_shift,
                        a_MAC_start, a_MAC_count, a_row_out, a_out_valid, a_busy, a_tile_done};
  wire [23:0] b_regs = {b_weight_load, b_weight_row, b_input_load, b_input_row,
                        b_partials_load, b_partials_row, b_fifo_shift, b_ps_fifo_shift,
                        b_MAC_start, b_MAC_count, b_row_out, b_out_valid, b_busy, b_tile_done};

  systolic_array_sequencer #(.N(4), .MAC_LAT(1)) dut_a (
    .CLK(CLK), .nRST(nRST), .weight_en(weight_en), .input_en(input_en),
    .partial_en(partial_en), .row_en(row_en), .fifo_has_space(fifo_has_space),
    .out_ready(out_ready), .bus_ready(a_bus_ready), .weight_load(a_weight_load),
    .weight_row(a_weight_row), .input_load(a_input_load), .input_row(a_input_row),
    .partials_load(a_partials_load), .partials_row(a_partials_row),
    .fifo_shift(a_fifo_shift), .ps_fifo_shift(a_ps_fifo_shift),
    .MAC_start(a_MAC_start), .MAC_count(a_MAC_count), .row_out(a_row_out),
    .out_valid(a_out_valid), .busy(a_busy), .tile_done(a_tile_done),
    .dbg_state(a_dbg_state)
  );

  systolic_array_sequencer #(.N(4), .MAC_LAT(3)) dut_b (
    .CLK(CLK), .nRST(nRST), .weight_en(weight_en), .input_en(input_en),
    .partial_en(partial_en), .row_en(row_en), .fifo_has_space(fifo_has_space),
    .out_ready(out_ready), .bus_ready(b_bus_ready), .weight_load(b_weight_load),
    .weight_row(b_weight_row), .input_load(b_input_load), .input_row(b_input_row),
    .partials_load(b_partials_load), .partials_row(b_partials_row),
    .fifo_shift(b_fifo_shift), .ps_fifo_shift(b_ps_fifo_shift),
    .MAC_start(b_MAC_start), .MAC_count(b_MAC_count), .row_out(b_row_out),
    .out_valid(b_out_valid), .busy(b_busy), .tile_done(b_tile_done),
    .dbg_state(b_dbg_state)
  );

  // Clock
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Load-pulse monitor (MAC_LAT=1 instance)
  always @(negedge CLK) begin
    if (mon_en && (a_weight_load || a_input_load || a_partials_load)) begin
      logic [4:0] act;
      act = {a_weight_load, a_input_load, a_partials_load,
             a_weight_load ? a_weight_row : (a_input_load ? a_input_row : a_partials_row)};
      if (load_exp_q.size() == 0) check("a_load_unexpected", load_exp_q.size(), 1);
      else check("a_load", act, load_exp_q.pop_front());
    end
  end

  // Compute/drain monitor, MAC_LAT=1 instance
  always @(negedge CLK) begin
    if (mon_en) begin
      if (a_MAC_count) begin
        if (cmpa_exp_q.size() == 0) check("a_compute_overrun", cmpa_exp_q.size(), 1);
        else check("a_compute", {a_MAC_start, a_fifo_shift, a_ps_fifo_shift}, cmpa_exp_q.pop_front());
      end else if ({a_MAC_start, a_fifo_shift, a_ps_fifo_shift} != 9'd0) begin
        check("a_ctrl_idle", {a_MAC_start, a_fifo_shift, a_ps_fifo_shift}, 0);
      end
      if (a_tile_done || a_done_exp) check("a_tile_done", a_tile_done, a_done_exp);
      a_done_exp = 1'b0;
      if (a_out_valid && !out_ready && rowa_exp_q.size() > 0)
        check("a_row_stall", a_row_out, rowa_exp_q[0]);
      if (a_out_valid && out_ready) begin
        if (rowa_exp_q.size() == 0) check("a_row_unexpected", rowa_exp_q.size(), 1);
        else begin
          logic [1:0] e;
          e = rowa_exp_q.pop_front();
          check("a_row_out", a_row_out, e);
          if (e == 2'd3) a_done_exp = 1'b1;
        end
      end
    end
  end

  // Compute/drain monitor, MAC_LAT=3 instance
  always @(negedge CLK) begin
    if (mon_en) begin
      if (b_MAC_count) begin
        if (cmpb_exp_q.size() == 0) check("b_compute_overrun", cmpb_exp_q.size(), 1);
        else check("b_compute", {b_MAC_start, b_fifo_shift, b_ps_fifo_shift}, cmpb_exp_q.pop_front());
      end else if ({b_MAC_start, b_fifo_shift, b_ps_fifo_shift} != 9'd0) begin
        check("b_ctrl_idle", {b_MAC_start, b_fifo_shift, b_ps_fifo_shift}, 0);
      end
      if (b_tile_done || b_done_exp) check("b_tile_done", b_tile_done, b_done_exp);
      b_done_exp = 1'b0;
      if (b_out_valid && !out_ready && rowb_exp_q.size() > 0)
        check("b_row_stall", b_row_out, rowb_exp_q[0]);
      if (b_out_valid && out_ready) begin
        if (rowb_exp_q.size() == 0) check("b_row_unexpected", rowb_exp_q.size(), 1);
        else begin
          logic [1:0] e;
          e = rowb_exp_q.pop_front();
          check("b_row_out", b_row_out, e);
          if (e == 2'd3) b_done_exp = 1'b1;
        end
      end
    end
  end

  // Driver: one bus word, issued at posedge+1, accepted at the next edge.
  task automatic do_load(input logic w, input logic i, input logic p,
                         input logic [1:0] row, input logic [4:0] exp);
    load_exp_q.push_back(exp);
    weight_en = w; input_en = i; partial_en = p; row_en = row;
    @(posedge CLK); #1;
    weight_en = 1'b0; input_en = 1'b0; partial_en = 1'b0;
  endtask

  task automatic load_entry(input int k);
    do_load(tile_tab[k][4], tile_tab[k][3], tile_tab[k][2], tile_tab[k][1:0], tile_tab[k]);
  endtask

  task automatic push_compute();
    for (int s = 0; s < 10; s++)
      cmpa_exp_q.push_back({(s == 0) ? 1'b1 : 1'b0, fs_tab[s], ps_tab[s]});
    for (int k = 0; k < 30; k++)
      cmpb_exp_q.push_back({(k == 0) ? 1'b1 : 1'b0,
                            (k % 3 == 0) ? fs_tab[k / 3] : 4'd0,
                            (k % 3 == 0) ? ps_tab[k / 3] : 4'd0});
  endtask

  task automatic push_rows();
    for (int r = 0; r < 4; r++) begin
      rowa_exp_q.push_back(2'(r));
      rowb_exp_q.push_back(2'(r));
    end
  endtask

  task automatic wait_for(input int which, input int budget, input string name);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(negedge CLK);
      hit = (which == 0) ? a_out_valid : (which == 1) ? b_out_valid : b_tile_done;
    end
    check(name, hit, 1);
  endtask

  task automatic check_queues_empty(input string tag);
    check({tag, "_load_q"}, load_exp_q.size(), 0);
    check({tag, "_cmpa_q"}, cmpa_exp_q.size(), 0);
    check({tag, "_cmpb_q"}, cmpb_exp_q.size(), 0);
    check({tag, "_rowa_q"}, rowa_exp_q.size(), 0);
    check({tag, "_rowb_q"}, rowb_exp_q.size(), 0);
  endtask

  initial begin
    logic [5:0] pat;
    fs_tab = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    ps_tab = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    tile_tab = '{5'b10000, 5'b10001, 5'b10010, 5'b10011,
                 5'b01000, 5'b01001, 5'b01010, 5'b01011,
                 5'b00100, 5'b00101, 5'b00110, 5'b00111};
    pat = 6'b101101;

    // Reset
    nRST = 1'b0; weight_en = 1'b0; input_en = 1'b0; partial_en = 1'b0;
    row_en = 2'd0; fifo_has_space = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("a_reset_regs", a_regs, 0);
    check("b_reset_regs", b_regs, 0);
    check("a_reset_state", a_dbg_state, 0);
    nRST = 1'b1;
    mon_en = 1'b1;

    // Backpressure: no space, so nothing is accepted
    weight_en = 1'b1; input_en = 1'b1; row_en = 2'd2;
    #1 check("bp_bus_ready", a_bus_ready, 0);
    @(posedge CLK); #1;
    check("bp_no_load", {a_weight_load, a_input_load, a_partials_load}, 0);
    weight_en = 1'b0; input_en = 1'b0;
    fifo_has_space = 1'b1;
    #1 check("bus_ready_open", a_bus_ready, 1);
    @(posedge CLK); #1;

    // Tile 1: priority drop, a reload, then full tile
    push_compute();
    do_load(1'b1, 1'b1, 1'b0, 2'd0, tile_tab[0]);
    for (int k = 1; k < 4; k++) load_entry(k);
    load_entry(1);
    for (int k = 4; k < 11; k++) load_entry(k);
    check("t1_not_full_busy", {a_busy, b_busy}, 0);
    load_entry(11);
    check("t1_mac_start", {a_MAC_start, a_busy, b_MAC_start}, 3'b111);

    // Drain A with ready pattern 1,0,1,1,0,1
    push_rows();
    wait_for(0, 20, "a_wait_drain");
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK); #1;
      out_ready = pat[k];
    end
    @(posedge CLK); #1;
    out_ready = 1'b0;
    @(posedge CLK); #1;
    check("a_back_to_load", {a_busy, a_out_valid, a_dbg_state}, 0);

    // Drain B (30-cycle compute)
    wait_for(1, 40, "b_wait_drain");
    @(posedge CLK); #1;
    out_ready = 1'b1;
    repeat (4) @(posedge CLK);
    #1 out_ready = 1'b0;
    @(posedge CLK); #1;
    check("b_back_to_load", {b_busy, b_out_valid, b_dbg_state}, 0);
    check_queues_empty("t1");

    // Tile 2: abandon mid-compute with a 2-cycle reset
    push_compute();
    for (int k = 0; k < 12; k++) load_entry(k);
    repeat (3) @(posedge CLK);
    #1;
    mon_en = 1'b0;
    nRST = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("a_midreset_regs", a_regs, 0);
    check("b_midreset_regs", b_regs, 0);
    check("midreset_state", {a_dbg_state, b_dbg_state}, 0);
    nRST = 1'b1;
    load_exp_q.delete(); cmpa_exp_q.delete(); cmpb_exp_q.delete();
    rowa_exp_q.delete(); rowb_exp_q.delete();
    a_done_exp = 1'b0; b_done_exp = 1'b0;
    mon_en = 1'b1;
    @(posedge CLK); #1;
    check("post_reset_load", {a_bus_ready, a_busy, a_tile_done, b_busy}, 4'b1000);

    // Tile 3: masks must start clear; full run with ready held high
    push_compute();
    for (int k = 0; k < 11; k++) load_entry(k);
    check("t3_not_full_busy", {a_busy, b_busy}, 0);
    load_entry(11);
    check("t3_mac_start", {a_MAC_start, b_MAC_start}, 2'b11);
    push_rows();
    out_ready = 1'b1;
    wait_for(2, 80, "b_wait_done");
    @(posedge CLK); #1;
    out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("t3_idle", {a_busy, b_busy, a_out_valid, b_out_valid}, 0);
    check_queues_empty("t3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
